wb_arb: RTL and testbench

Writeback arbiter for GPR results. N_REQ result sources (ALU, MUL/DIV, LSU, external load) compete for N_WB writeback slots per cycle. Each granted slot drives one register-file write port and the matching scoreboard "set operand ready" port. A round-robin rotating priority guarantees forward progress, and the outputs are registered.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_arb_if.sv | 42 ++++
 rtl/wb_arb_pick.sv | 64 ++++++
 rtl/wb_arb.sv | 79 +++++++
 tb/tb_wb_arb.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared GPR constants and the writeback request bundle.
// Imported by the arbiter, its picker and the requester-side paths.
package wb_arb_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int NUM_GPR   = 32;
  localparam int CORE_XLEN = 32;

  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  typedef struct packed {
    gpr_idx_t             rd;
    logic [CORE_XLEN-1:0] data;
  } wb_req_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arb_if.sv
// wb_arb_if: result requesters on one side, registered writeback
// slots (regfile write + scoreboard set-ready) on the other.
interface wb_arb_if
  import wb_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_WB  = 2,
  parameter int XLEN  = 32
) ();

  logic [N_REQ-1:0]           req_val;
  gpr_idx_t [N_REQ-1:0]       req_rd;
  logic [N_REQ-1:0][XLEN-1:0] req_data;
  logic [N_REQ-1:0]           req_rdy;
  logic                       wb_stall;
  logic [N_WB-1:0]            wb_val;
  gpr_idx_t [N_WB-1:0]        wb_rd;
  logic [N_WB-1:0][XLEN-1:0]  wb_data;

  modport master (
    output req_val,
    output req_rd,
    output req_data,
    output wb_stall,
    input  req_rdy,
    input  wb_val,
    input  wb_rd,
    input  wb_data
  );

  modport slave (
    input  req_val,
    input  req_rd,
    input  req_data,
    input  wb_stall,
    output req_rdy,
    output wb_val,
    output wb_rd,
    output wb_data
  );

endinterface

// File: rtl/wb_arb_pick.sv
// wb_arb_pick: circular multi-grant picker, up to N_WB grants per
// cycle starting at rr_ptr, skipping requesters whose rd clashes.
module wb_arb_pick
  import wb_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_WB  = 2,
  localparam int PW   = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0]     req_val_i,
  input  gpr_idx_t [N_REQ-1:0] req_rd_i,
  input  logic [PW-1:0]        rr_ptr_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_WB-1:0]      slot_val_o,
  output logic [N_WB-1:0][PW-1:0] slot_idx_o,
  output logic [PW-1:0]        nxt_ptr_o
);

  localparam int SW = $clog2(N_WB + 1);

  int            pos;
  int            nxt;
  logic [PW-1:0] ix;
  logic [SW-1:0] n;
  logic          clash;

  always_comb begin
    gnt_o      = '0;
    slot_val_o = '0;
    slot_idx_o = '0;
    nxt_ptr_o  = rr_ptr_i;
    pos        = 0;
    nxt        = 0;
    ix         = '0;
    n          = '0;
    clash      = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      ix = PW'(pos);
      // x0 never blocks anyone; it has no scoreboard entry
      clash = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
        if (gnt_o[j] && req_rd_i[j] == req_rd_i[ix]
            && req_rd_i[ix] != '0)
          clash = 1'b1;
      end
      if (req_val_i[ix] && !clash && n < SW'(N_WB)) begin
        gnt_o[ix] = 1'b1;
        for (int s = 0; s < N_WB; s++) begin
          if (SW'(s) == n) begin
            slot_val_o[s] = 1'b1;
            slot_idx_o[s] = ix;
          end
        end
        n   = n + 1'b1;
        nxt = pos + 1;
        if (nxt >= N_REQ) nxt = 0;
        nxt_ptr_o = PW'(nxt);
      end
    end
  end

endmodule

// File: rtl/wb_arb.sv
// wb_arb: GPR writeback arbiter with stall gating, rotating priority
// and registered writeback slots.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_WB  = 2,
  parameter int XLEN  = 32
) (
  input logic     clk,
  input logic     rst_n,
  wb_arb_if.slave bus
);

  localparam int PW = ptr_w(N_REQ);

  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]          val_gated;
  logic [N_REQ-1:0]          gnt;
  logic [N_WB-1:0]           slot_val;
  logic [N_WB-1:0][PW-1:0]   slot_idx;
  logic [PW-1:0]             nxt_ptr;

  logic [N_WB-1:0]           wb_val_q, wb_val_d;
  gpr_idx_t [N_WB-1:0]       wb_rd_q, wb_rd_d;
  logic [N_WB-1:0][XLEN-1:0] wb_data_q, wb_data_d;

  // no grant while in reset or while the port is borrowed
  assign val_gated = (rst_n && !bus.wb_stall) ? bus.req_val : '0;

  wb_arb_pick #(
    .N_REQ (N_REQ),
    .N_WB  (N_WB)
  ) u_pick (
    .req_val_i  (val_gated),
    .req_rd_i   (bus.req_rd),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_o      (gnt),
    .slot_val_o (slot_val),
    .slot_idx_o (slot_idx),
    .nxt_ptr_o  (nxt_ptr)
  );

  assign bus.req_rdy = gnt;

  always_comb begin
    rr_ptr_d  = (|gnt) ? nxt_ptr : rr_ptr_q;
    wb_val_d  = '0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    for (int s = 0; s < N_WB; s++) begin
      if (slot_val[s]) begin
        wb_rd_d[s]   = bus.req_rd[slot_idx[s]];
        wb_data_d[s] = bus.req_data[slot_idx[s]];
        // x0 consumes the slot but never writes
        wb_val_d[s]  = (bus.req_rd[slot_idx[s]] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      wb_val_q  <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wb_val_q  <= wb_val_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.wb_val  = wb_val_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: directed and random checks of wb_arb against a
// scan-order reference model (N_WB=2 instance plus N_WB=1 instance).
module tb_wb_arb;
  import wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arb_if #(.N_REQ(4), .N_WB(2), .XLEN(32)) bus ();
  wb_arb_if #(.N_REQ(4), .N_WB(1), .XLEN(32)) bus1 ();

  wb_arb #(.N_REQ(4), .N_WB(2), .XLEN(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_arb #(.N_REQ(4), .N_WB(1), .XLEN(32)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int mptr   = 0;
  int mptr1  = 0;
  int nwr    = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk requesters in circular order from ptr, grant while
  // slots remain and the nonzero rd is not already in the granted set.
  function automatic void model(
    input  logic [3:0]      v,
    input  logic [3:0][4:0] rd,
    input  logic            stall,
    input  int              ptr,
    input  int              nwb,
    output logic [3:0]      g,
    output logic [1:0][1:0] sl,
    output int              ns,
    output int              np
  );
    logic [4:0] taken[$];
    g  = '0;
    sl = '0;
    ns = 0;
    np = ptr;
    if (!stall) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (ptr + k) % 4;
        if (ns < nwb && v[i] && !(rd[i] != 0 && (rd[i] inside {taken}))) begin
          g[i]   = 1'b1;
          sl[ns] = 2'(i);
          ns++;
          np = (i + 1) % 4;
          if (rd[i] != 0) taken.push_back(rd[i]);
        end
      end
    end
  endfunction

  task automatic stepA(input string tag, output logic [3:0] g);
    logic [1:0][1:0] sl;
    int      ns, np;
    wb_req_t e[2];
    logic    ev;
    #2;
    model(bus.req_val, bus.req_rd, bus.wb_stall, mptr, 2, g, sl, ns, np);
    chk({tag, ".rdy"}, 64'(bus.req_rdy), 64'(g));
    chk({tag, ".ptr"}, 64'(u_dut.rr_ptr_q), 64'(mptr));
    for (int s = 0; s < 2; s++) begin
      e[s].rd   = bus.req_rd[sl[s]];
      e[s].data = bus.req_data[sl[s]];
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      ev = (s < ns) && (e[s].rd != 0);
      chk($sformatf("%s.val%0d", tag, s), 64'(bus.wb_val[s]), 64'(ev));
      if (ev) begin
        chk($sformatf("%s.rd%0d", tag, s), 64'(bus.wb_rd[s]), 64'(e[s].rd));
        chk($sformatf("%s.dat%0d", tag, s), 64'(bus.wb_data[s]),
            64'(e[s].data));
      end
      if (bus.wb_val[s]) nwr++;
    end
    mptr = np;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.wb_stall  = 1'b0;
    bus1.wb_stall = 1'b0;
    bus.req_val   = 4'b1111;
    bus1.req_val  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_rd[i]  = 5'(i + 1);
      bus1.req_rd[i] = 5'(i + 1);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst.rdy", 64'(bus.req_rdy), 64'(0));
      chk("rst.rdy1", 64'(bus1.req_rdy), 64'(0));
      chk("rst.val", 64'(bus.wb_val), 64'(0));
    end
    bus.req_val  = '0;
    bus1.req_val = '0;
    rst_n = 1'b1;
    mptr  = 0;
    mptr1 = 0;
    #1;
    chk("rst.ptr", 64'(u_dut.rr_ptr_q), 64'(0));
    chk("rst.ptr1", 64'(u_dut1.rr_ptr_q), 64'(0));
    chk("rst.wbval", 64'(bus.wb_val), 64'(0));
    chk("rst.wbrd", 64'(bus.wb_rd), 64'(0));
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] g1;
    logic [1:0][1:0] sl1;
    int ns1, np1;
    int pat [4] = '{0, 3, 0, 3};

    bus.req_val   = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.wb_stall  = 1'b0;
    bus1.req_val  = '0;
    bus1.req_rd   = '0;
    bus1.req_data = '0;
    bus1.wb_stall = 1'b0;

    do_reset();

    // single request
    bus.req_val     = 4'b0001;
    bus.req_rd[0]   = 5'd5;
    bus.req_data[0] = 32'hDEADBEEF;
    stepA("single", g);
    chk("single.wbval", 64'(bus.wb_val), 64'(2'b01));
    chk("single.wbrd", 64'(bus.wb_rd[0]), 64'(5));
    chk("single.wbdat", 64'(bus.wb_data[0]), 64'(32'hDEADBEEF));
    bus.req_val = bus.req_val & ~g;
    stepA("idle", g);
    chk("idle.wbval", 64'(bus.wb_val), 64'(0));

    // oversubscription
    do_reset();
    bus.req_val = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_rd[i]   = 5'(i + 1);
      bus.req_data[i] = $urandom;
    end
    nwr = 0;
    stepA("over0", g);
    chk("over0.wbrd", 64'(bus.wb_rd), 64'({5'd2, 5'd1}));
    bus.req_val = bus.req_val & ~g;
    stepA("over1", g);
    chk("over1.wbrd", 64'(bus.wb_rd), 64'({5'd4, 5'd3}));
    chk("over1.wbval", 64'(bus.wb_val), 64'(2'b11));
    bus.req_val = bus.req_val & ~g;
    stepA("over2", g);
    chk("over.writes", 64'(nwr), 64'(4));

    // same-rd conflict
    do_reset();
    bus.req_val     = 4'b0011;
    bus.req_rd[0]   = 5'd7;
    bus.req_rd[1]   = 5'd7;
    bus.req_data[0] = 32'h0000AAAA;
    bus.req_data[1] = 32'h0000BBBB;
    stepA("conf0", g);
    chk("conf0.wbval", 64'(bus.wb_val), 64'(2'b01));
    chk("conf0.wbdat", 64'(bus.wb_data[0]), 64'(32'h0000AAAA));
    bus.req_val = bus.req_val & ~g;
    stepA("conf1", g);
    chk("conf1.wbval", 64'(bus.wb_val), 64'(2'b01));
    chk("conf1.wbdat", 64'(bus.wb_data[0]), 64'(32'h0000BBBB));
    bus.req_val = bus.req_val & ~g;

    // x0 result
    bus.req_val     = 4'b0100;
    bus.req_rd[2]   = 5'd0;
    bus.req_data[2] = 32'h12345678;
    stepA("x0", g);
    chk("x0.gnt", 64'(g), 64'(4'b0100));
    chk("x0.wbval", 64'(bus.wb_val), 64'(0));
    bus.req_val = bus.req_val & ~g;

    // stall
    bus.wb_stall    = 1'b1;
    bus.req_val     = 4'b0010;
    bus.req_rd[1]   = 5'd9;
    bus.req_data[1] = 32'hCAFE0009;
    repeat (3) begin
      stepA("stall", g);
      chk("stall.wbval", 64'(bus.wb_val), 64'(0));
    end
    bus.wb_stall = 1'b0;
    stepA("unstall", g);
    chk("unstall.wbval", 64'(bus.wb_val), 64'(2'b01));
    chk("unstall.wbrd", 64'(bus.wb_rd[0]), 64'(9));
    bus.req_val = bus.req_val & ~g;
    g = '0;

    // random traffic, requesters hold until accepted
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_val[i] || g[i]) begin
          bus.req_val[i]  = 1'($urandom_range(0, 1));
          bus.req_rd[i]   = 5'($urandom_range(0, 7));
          bus.req_data[i] = $urandom;
        end
      end
      bus.wb_stall = ($urandom_range(0, 7) == 0);
      stepA("rand", g);
    end
    bus.req_val  = '0;
    bus.wb_stall = 1'b0;

    // fairness on the single-slot instance
    do_reset();
    bus1.req_val   = 4'b1001;
    bus1.req_rd[0] = 5'd1;
    bus1.req_rd[3] = 5'd2;
    for (int c = 0; c < 8; c++) begin
      bus1.req_data[0] = $urandom;
      bus1.req_data[3] = $urandom;
      #2;
      model(bus1.req_val, bus1.req_rd, 1'b0, mptr1, 1, g1, sl1, ns1, np1);
      chk("fair.model", 64'(bus1.req_rdy), 64'(g1));
      chk("fair.rdy", 64'(bus1.req_rdy), 64'(4'b0001 << pat[c % 4]));
      @(posedge clk);
      #1;
      chk("fair.wbval", 64'(bus1.wb_val), 64'(1));
      chk("fair.wbrd", 64'(bus1.wb_rd[0]),
          64'((pat[c % 4] == 0) ? 1 : 2));
      mptr1 = np1;
    end
    bus1.req_val = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
